// File: rtl/y86_pkg.sv
// Shared Y86 encodings for the execute stage: instruction codes, ALU and
// condition function codes, condition-code bit positions and the branch test.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

  // Condition test shared by cmovXX and jXX; undefined codes never fire.
  function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
    logic zf, sf, of;
    zf = cc[CC_ZF];
    sf = cc[CC_SF];
    of = cc[CC_OF];
    case (ifun)
      C_YES:   return 1'b1;
      C_LE:    return (sf ^ of) | zf;
      C_L:     return sf ^ of;
      C_E:     return zf;
      C_NE:    return !zf;
      C_GE:    return !(sf ^ of);
      C_G:     return !(sf ^ of) & !zf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_alu_core.sv
// Combinational OPq ALU: computes valB op valA and the ZF/SF/OF flags,
// flagging any function code outside add/sub/and/xor as illegal.
module y86_alu_core
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_ifun,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zf,
  output logic             o_sf,
  output logic             o_of,
  output logic             o_illegal
);

  logic [WIDTH-1:0] w_result;
  logic             w_of;
  logic             w_illegal;

  // Overflow is judged on sign bits; sub is valB - valA, so valB is the reference sign.
  always_comb begin
    w_result  = '0;
    w_of      = 1'b0;
    w_illegal = 1'b0;
    case (i_ifun)
      ALU_ADD: begin
        w_result = i_b + i_a;
        w_of     = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_result[WIDTH-1] != i_b[WIDTH-1]);
      end
      ALU_SUB: begin
        w_result = i_b - i_a;
        w_of     = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_result[WIDTH-1] != i_b[WIDTH-1]);
      end
      ALU_AND: w_result = i_b & i_a;
      ALU_XOR: w_result = i_b ^ i_a;
      default: w_illegal = 1'b1;
    endcase
  end

  assign o_result  = w_result;
  assign o_zf      = (w_result == '0);
  assign o_sf      = w_result[WIDTH-1];
  assign o_of      = w_of;
  assign o_illegal = w_illegal;

endmodule

// File: rtl/y86_execute_unit.sv
// Registered Y86 execute stage: valE selection, condition codes, cnd evaluation
// and a one-deep valid/ready output register usable for both SEQ and PIPE.
module y86_execute_unit
  import y86_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int STACK_STEP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  input  logic             set_cc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic [3:0]       out_ifun,
  output logic [WIDTH-1:0] valE,
  output logic             cnd,
  output logic             err,
  output logic [2:0]       cc
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

  logic             r_out_valid;
  logic [3:0]       r_icode;
  logic [3:0]       r_ifun;
  logic [WIDTH-1:0] r_valE;
  logic             r_cnd;
  logic             r_err;
  logic [2:0]       r_cc;

  logic             w_accept;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_zf;
  logic             w_alu_sf;
  logic             w_alu_of;
  logic             w_alu_illegal;
  logic [WIDTH-1:0] w_valE;
  logic             w_cnd;
  logic             w_err;
  logic             w_cc_we;

  assign in_ready = !r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  y86_alu_core #(.WIDTH(WIDTH)) u_alu (
    .i_a       (valA),
    .i_b       (valB),
    .i_ifun    (ifun),
    .o_result  (w_alu_result),
    .o_zf      (w_alu_zf),
    .o_sf      (w_alu_sf),
    .o_of      (w_alu_of),
    .o_illegal (w_alu_illegal)
  );

  // cnd reads r_cc directly, so an OPq accepted on the previous edge is already visible.
  always_comb begin
    w_valE  = '0;
    w_cnd   = 1'b0;
    w_err   = 1'b0;
    w_cc_we = 1'b0;
    case (icode)
      I_HALT, I_NOP: ;
      I_CMOVXX: begin
        if (ifun > C_G) begin
          w_err = 1'b1;
        end else begin
          w_valE = valA;
          w_cnd  = cond_eval(ifun, r_cc);
        end
      end
      I_IRMOVQ:          w_valE = valC;
      I_RMMOVQ, I_MRMOVQ: w_valE = valB + valC;
      I_OPQ: begin
        if (w_alu_illegal) begin
          w_err = 1'b1;
        end else begin
          w_valE  = w_alu_result;
          w_cc_we = set_cc_en;
        end
      end
      I_JXX: begin
        if (ifun > C_G) w_err = 1'b1;
        else            w_cnd = cond_eval(ifun, r_cc);
      end
      I_CALL, I_PUSHQ: w_valE = valB - STEP;
      I_RET, I_POPQ:   w_valE = valB + STEP;
      default:         w_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc <= CC_RESET;
    end else if (w_accept && w_cc_we) begin
      r_cc <= {w_alu_zf, w_alu_sf, w_alu_of};
    end
  end

  // Loads on accept, otherwise drains on out_ready and holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_icode     <= 4'h0;
      r_ifun      <= 4'h0;
      r_valE      <= '0;
      r_cnd       <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_icode     <= icode;
      r_ifun      <= ifun;
      r_valE      <= w_valE;
      r_cnd       <= w_cnd;
      r_err       <= w_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_icode = r_icode;
  assign out_ifun  = r_ifun;
  assign valE      = r_valE;
  assign cnd       = r_cnd;
  assign err       = r_err;
  assign cc        = r_cc;

endmodule

// File: tb/tb_y86_execute_unit.sv
// Table-driven scoreboard bench for y86_execute_unit (64-bit instance, plus a
// 32-bit instance fed the same stream for the stack wrap rows).
module tb_y86_execute_unit;

  typedef struct {
    int          id;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic        setCc;
    logic [63:0] expValE;
    logic        expCnd;
    logic        expErr;
    logic [2:0]  expCc;
    logic        chk32;
    logic [31:0] expValE32;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic        set_cc_en;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_icode;
  logic [3:0]  out_ifun;
  logic [63:0] valE;
  logic        cnd;
  logic        err;
  logic [2:0]  cc;

  logic        inReady32;
  logic        outValid32;
  logic [3:0]  outIcode32;
  logic [3:0]  outIfun32;
  logic [31:0] valE32;
  logic        cnd32;
  logic        err32;
  logic [2:0]  cc32;

  int testsRun    = 0;
  int testsFailed = 0;

  vec_t vecs[$];
  vec_t expQ[$];

  y86_execute_unit #(.WIDTH(64), .STACK_STEP(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .icode     (icode),
    .ifun      (ifun),
    .valA      (valA),
    .valB      (valB),
    .valC      (valC),
    .set_cc_en (set_cc_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_icode (out_icode),
    .out_ifun  (out_ifun),
    .valE      (valE),
    .cnd       (cnd),
    .err       (err),
    .cc        (cc)
  );

  y86_execute_unit #(.WIDTH(32), .STACK_STEP(8)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (inReady32),
    .icode     (icode),
    .ifun      (ifun),
    .valA      (valA[31:0]),
    .valB      (valB[31:0]),
    .valC      (valC[31:0]),
    .set_cc_en (set_cc_en),
    .out_valid (outValid32),
    .out_ready (out_ready),
    .out_icode (outIcode32),
    .out_ifun  (outIfun32),
    .valE      (valE32),
    .cnd       (cnd32),
    .err       (err32),
    .cc        (cc32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c, input logic sc,
                        input logic [63:0] eValE, input logic eCnd, input logic eErr,
                        input logic [2:0] eCc, input logic c32, input logic [31:0] e32);
    vec_t v;
    v.id = vecs.size();
    v.icode = ic; v.ifun = fn; v.valA = a; v.valB = b; v.valC = c; v.setCc = sc;
    v.expValE = eValE; v.expCnd = eCnd; v.expErr = eErr; v.expCc = eCc;
    v.chk32 = c32; v.expValE32 = e32;
    vecs.push_back(v);
  endtask

  // Drives one instruction at the negedge and records its expectation once in_ready allows the accept.
  task automatic applyStimulus(input vec_t v);
    int waitCycles = 0;
    @(negedge clk);
    icode = v.icode; ifun = v.ifun; valA = v.valA; valB = v.valB; valC = v.valC;
    set_cc_en = v.setCc;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waitCycles < 20) begin
      @(negedge clk);
      #1;
      waitCycles++;
    end
    if (!in_ready) checkOutput($sformatf("v%0d accept timeout", v.id), 64'(in_ready), 64'd1);
    else           expQ.push_back(v);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Scoreboard: each result is compared exactly once, in the cycle it is consumed.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected output", 64'(out_valid), 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("v%0d icode", e.id), 64'(out_icode), 64'(e.icode));
          checkOutput($sformatf("v%0d ifun", e.id),  64'(out_ifun),  64'(e.ifun));
          checkOutput($sformatf("v%0d valE", e.id),  valE,           e.expValE);
          checkOutput($sformatf("v%0d cnd", e.id),   64'(cnd),       64'(e.expCnd));
          checkOutput($sformatf("v%0d err", e.id),   64'(err),       64'(e.expErr));
          checkOutput($sformatf("v%0d cc", e.id),    64'(cc),        64'(e.expCc));
          if (e.chk32) checkOutput($sformatf("v%0d valE32", e.id), 64'(valE32), 64'(e.expValE32));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t bp1, bp2, rs1, rs2;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; set_cc_en = 1'b1;
    icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0;

    //      icode ifun valA                   valB                   valC     sc  expValE                cnd err cc    c32 exp32
    addVec(4'h1, 4'h0, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 0,  0, 3'b100, 0, 32'h0);
    addVec(4'h6, 4'h0, 64'h1,                 64'h7FFF_FFFF_FFFF_FFFF, 64'h0,  1, 64'h8000_0000_0000_0000, 0, 0, 3'b011, 0, 32'h0);
    addVec(4'h7, 4'h2, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 0,  0, 3'b011, 0, 32'h0);
    addVec(4'h7, 4'h1, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 0,  0, 3'b011, 0, 32'h0);
    addVec(4'h6, 4'h1, 64'h5,                 64'h5,                 64'h0,    1, 64'h0,                 0,  0, 3'b100, 0, 32'h0);
    addVec(4'h7, 4'h3, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 1,  0, 3'b100, 0, 32'h0);
    addVec(4'h7, 4'h4, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 0,  0, 3'b100, 0, 32'h0);
    addVec(4'h2, 4'h6, 64'h42,                64'h0,                 64'h0,    1, 64'h42,                0,  0, 3'b100, 0, 32'h0);
    addVec(4'h2, 4'h0, 64'h11,                64'h0,                 64'h0,    1, 64'h11,                1,  0, 3'b100, 0, 32'h0);
    addVec(4'h7, 4'h0, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 1,  0, 3'b100, 0, 32'h0);
    addVec(4'h6, 4'h2, 64'h0F,                64'hF0,                64'h0,    1, 64'h0,                 0,  0, 3'b100, 0, 32'h0);
    addVec(4'h6, 4'h3, 64'h0F0F,              64'hFF00,              64'h0,    1, 64'hF00F,              0,  0, 3'b000, 0, 32'h0);
    addVec(4'h7, 4'h5, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 1,  0, 3'b000, 0, 32'h0);
    addVec(4'h7, 4'h6, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 1,  0, 3'b000, 0, 32'h0);
    addVec(4'h2, 4'h4, 64'h7,                 64'h0,                 64'h0,    1, 64'h7,                 1,  0, 3'b000, 0, 32'h0);
    addVec(4'h6, 4'h1, 64'h2,                 64'h1,                 64'h0,    1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 3'b010, 0, 32'h0);
    addVec(4'h7, 4'h1, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 1,  0, 3'b010, 0, 32'h0);
    addVec(4'h7, 4'h2, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 1,  0, 3'b010, 0, 32'h0);
    addVec(4'h2, 4'h5, 64'h9,                 64'h0,                 64'h0,    1, 64'h9,                 0,  0, 3'b010, 0, 32'h0);
    addVec(4'h6, 4'h1, 64'h1,                 64'h8000_0000_0000_0000, 64'h0,  1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 3'b001, 0, 32'h0);
    addVec(4'h7, 4'h2, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 1,  0, 3'b001, 0, 32'h0);
    addVec(4'h7, 4'h6, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 0,  0, 3'b001, 0, 32'h0);
    addVec(4'h6, 4'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1, 64'h0,               0,  0, 3'b101, 0, 32'h0);
    addVec(4'h7, 4'h1, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 1,  0, 3'b101, 0, 32'h0);
    addVec(4'h7, 4'h3, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 1,  0, 3'b101, 0, 32'h0);
    addVec(4'h7, 4'h5, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 0,  0, 3'b101, 0, 32'h0);
    addVec(4'h3, 4'h0, 64'h0,                 64'h0,                 64'h1234, 1, 64'h1234,              0,  0, 3'b101, 0, 32'h0);
    addVec(4'h4, 4'h0, 64'h0,                 64'h100,               64'h10,   1, 64'h110,               0,  0, 3'b101, 0, 32'h0);
    addVec(4'h5, 4'h0, 64'h0,                 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1, 64'h10,                0,  0, 3'b101, 0, 32'h0);
    addVec(4'hA, 4'h0, 64'h0,                 64'h100,               64'h0,    1, 64'hF8,                0,  0, 3'b101, 1, 32'hF8);
    addVec(4'hB, 4'h0, 64'h0,                 64'h100,               64'h0,    1, 64'h108,               0,  0, 3'b101, 1, 32'h108);
    addVec(4'h8, 4'h0, 64'h0,                 64'h0,                 64'h0,    1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 3'b101, 1, 32'hFFFF_FFF8);
    addVec(4'h9, 4'h0, 64'h0,                 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,  1, 64'h0,                 0,  0, 3'b101, 1, 32'h0);
    addVec(4'hC, 4'h0, 64'h3,                 64'h4,                 64'h5,    1, 64'h0,                 0,  1, 3'b101, 0, 32'h0);
    addVec(4'hF, 4'h0, 64'h3,                 64'h4,                 64'h5,    1, 64'h0,                 0,  1, 3'b101, 0, 32'h0);
    addVec(4'h6, 4'h5, 64'h1,                 64'h1,                 64'h0,    1, 64'h0,                 0,  1, 3'b101, 0, 32'h0);
    addVec(4'h7, 4'h7, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 0,  1, 3'b101, 0, 32'h0);
    addVec(4'h2, 4'h9, 64'h55,                64'h0,                 64'h0,    1, 64'h0,                 0,  1, 3'b101, 0, 32'h0);
    addVec(4'h6, 4'h1, 64'h2,                 64'h1,                 64'h0,    0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 3'b101, 0, 32'h0);
    addVec(4'h0, 4'h0, 64'h0,                 64'h0,                 64'h0,    1, 64'h0,                 0,  0, 3'b101, 0, 32'h0);

    #12;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset valE",      valE,           64'd0);
    checkOutput("reset cnd",       64'(cnd),       64'd0);
    checkOutput("reset err",       64'(err),       64'd0);
    checkOutput("reset out_icode", 64'(out_icode), 64'd0);
    checkOutput("reset out_ifun",  64'(out_ifun),  64'd0);
    checkOutput("reset cc",        64'(cc),        64'(3'b100));
    checkOutput("reset in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream at full throughput.
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);
    idle(3);

    // Backpressure: second OPq must wait and must not touch cc until accepted.
    bp1 = vecs[0]; bp1.id = 100; bp1.icode = 4'h6; bp1.ifun = 4'h0; bp1.valA = 64'h1; bp1.valB = 64'h1;
    bp1.expValE = 64'h2; bp1.expCc = 3'b000; bp1.expCnd = 0; bp1.expErr = 0; bp1.setCc = 1; bp1.chk32 = 0;
    bp2 = bp1; bp2.id = 101; bp2.ifun = 4'h1; bp2.valA = 64'h5; bp2.valB = 64'h3;
    bp2.expValE = 64'hFFFF_FFFF_FFFF_FFFE; bp2.expCc = 3'b010;
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(bp1);
    @(negedge clk);
    icode = bp2.icode; ifun = bp2.ifun; valA = bp2.valA; valB = bp2.valB; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("bp in_ready held %0d", i), 64'(in_ready), 64'd0);
      checkOutput($sformatf("bp cc first %0d", i),      64'(cc),       64'(3'b000));
      checkOutput($sformatf("bp valE held %0d", i),     valE,          64'h2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp in_ready release", 64'(in_ready), 64'd1);
    checkOutput("bp cc before second", 64'(cc),       64'(3'b000));
    expQ.push_back(bp2);
    idle(3);

    // Asynchronous reset while a result is held.
    rs1 = bp1; rs1.id = 200;
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(rs1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("pre-reset out_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("async reset cc",        64'(cc),        64'(3'b100));
    checkOutput("async reset in_ready",  64'(in_ready),  64'd1);
    checkOutput("async reset valE",      valE,           64'd0);
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    rs2 = vecs[5]; rs2.id = 201;
    applyStimulus(rs2);
    idle(4);

    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/y86_execute_unit.md
Name: y86_execute_unit

Overview:
Registered, parametrised Y86 execute stage. It computes valE for every icode and performs the full OPq ALU (add/sub/and/xor). It holds the ZF/SF/OF condition-code register and evaluates cnd for cmovXX and jXX. It sits between decode and memory and uses a valid/ready handshake so the same block serves SEQ (out_ready tied high) and PIPE (stall via out_ready).

Parameters:
WIDTH, 64, datapath width of valA/valB/valC/valE (legal: 16, 32, 64).
STACK_STEP, 8, byte adjustment applied to valB for call/ret/pushq/popq.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  decoded instruction present.
in_ready  output  1  stage can accept this cycle.
icode  input  4  instruction code.
ifun  input  4  function code.
valA  input  WIDTH  operand A.
valB  input  WIDTH  operand B.
valC  input  WIDTH  constant word.
set_cc_en  input  1  permits CC update; deasserted by pipeline control on downstream exception.
out_valid  output  1  registered result valid.
out_ready  input  1  downstream accepts result.
out_icode  output  4  registered icode.
out_ifun  output  4  registered ifun.
valE  output  WIDTH  registered execute result.
cnd  output  1  registered condition outcome.
err  output  1  registered illegal icode/ifun flag.
cc  output  3  current CC register {ZF,SF,OF}.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, valE=0, cnd=0, err=0, out_icode=0, out_ifun=0, cc=3'b100. Any pending result is dropped.
- Handshake: in_ready = !out_valid | out_ready.
- Accept on in_valid & in_ready. Results are registered at that edge, giving latency 1.
- Output register holds stable while out_valid & !out_ready.
- out_valid clears on out_ready when nothing is accepted in the same cycle.
- Full throughput: one instruction per cycle when out_ready=1.
- valE by icode, all arithmetic modulo 2^WIDTH (wrap, no saturation):
  - 0 halt / 1 nop: 0.
  - 2 cmovXX: valA.
  - 3 irmovq: valC.
  - 4 rmmovq / 5 mrmovq: valB+valC.
  - 6 OPq: ifun 0 gives valB+valA, 1 gives valB-valA, 2 gives valB&valA, 3 gives valB^valA.
  - 7 jXX: 0.
  - 8 call / A pushq: valB-STACK_STEP.
  - 9 ret / B popq: valB+STACK_STEP.
  - icode C-F: valE=0, err=1.
- Flags computed for OPq:
  - ZF = (result==0).
  - SF = result[WIDTH-1].
  - OF for add: operands have the same sign and the result sign differs.
  - OF for sub: valB and valA signs differ and the result sign differs from valB.
  - OF = 0 for and/xor.
- CC update: only when an OPq with ifun 0-3 is accepted and set_cc_en=1; the update lands at the same edge. All other cases leave cc unchanged.
- cnd evaluated only for icode 2 and 7, using cc as it stands before the accepting edge:
  - 0 always 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: !ZF.
  - 5 ge: !(SF^OF).
  - 6 g: !(SF^OF)&!ZF.
  - Other icodes give cnd=0.
- Back-to-back OPq then jXX/cmov: the later instruction sees the CC written by the earlier one (no hazard inside the block).
- Illegal ifun: OPq ifun>3 or cond ifun>6 gives err=1, valE=0, cnd=0, no CC update.
- Illegal instructions still complete the handshake normally.
- in_valid with in_ready=0: nothing is captured and CC is not touched, even for OPq.

Decomposition:
- Shared package y86_pkg:
  - icode constants (I_HALT..I_POPQ).
  - ALU ifun constants (ALU_ADD/SUB/AND/XOR).
  - condition ifun constants (C_YES..C_G).
  - CC bit indices (CC_ZF=2, CC_SF=1, CC_OF=0).
- One sub-module y86_alu_core, parametrised by WIDTH and purely combinational:
  - inputs: operands and ifun.
  - outputs: result, ZF, SF, OF, illegal.
- The top level holds the CC register, the condition evaluation, the valE mux and the output register/handshake.

Test Plan:
- Reset: assert rst_n=0 mid-transfer with out_valid=1 -> out_valid=0, cc=100, in_ready=1 immediately (asynchronously).
- Add overflow (WIDTH=64): OPq ifun0, valB=0x7FFF_FFFF_FFFF_FFFF, valA=1 -> next cycle valE=0x8000_0000_0000_0000, cc=010+OF=011 (ZF0 SF1 OF1).
- Compare then branch: OPq sub valB=5, valA=5 -> valE=0, cc=100; back-to-back jXX ifun3 -> cnd=1; then jXX ifun4 -> cnd=0; then cmov ifun6 valA=0x42 -> valE=0x42, cnd=0.
- Backpressure: out_ready=0 and two OPq issued -> first held, in_ready=0, second not captured and cc reflects only the first. Release out_ready -> second completes and cc updates one cycle later.
- Stack/wrap: pushq valB=0x100 -> valE=0xF8; popq valB=0x100 -> 0x108; call valB=0 -> 0xFFFF_FFFF_FFFF_FFF8. Repeat with WIDTH=32 -> 0xFFFF_FFF8.
- Errors/gating: icode 0xC -> err=1, valE=0. OPq ifun5 -> err=1, cc unchanged. OPq sub 1-2 with set_cc_en=0 -> valE=all-ones, cc unchanged.
